// File: rtl/mat_pkg.sv
// mat_pkg: shared constants and types for the matrix coding pipeline.
//   MAT_DW      coefficient width (two's complement)
//   MAT_BLK_N   samples per 8x8 block
//   MAT_RW      run field width, $clog2(MAT_BLK_N)
//   MAT_ZRL_RUN run value of a zero-run-length word (optional ZRL feature)
//   rle_pair_t  one run/level/eob output word
package mat_pkg;

  localparam int         MAT_DW      = 10;
  localparam int         MAT_BLK_N   = 64;
  localparam int         MAT_RW      = 6;
  localparam logic [3:0] MAT_ZRL_RUN = 4'd15;

  typedef struct packed {
    logic [MAT_RW-1:0] run;
    logic [MAT_DW-1:0] level;
    logic              eob;
  } rle_pair_t;

endpackage

// File: rtl/mat_pos_cnt.sv
// mat_pos_cnt: modulo-BLK_N position counter for the run-length encoder.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   adv    in   advance the position (an accepted sample)
//   pos    out  current position 0..BLK_N-1 (position of the sample on din now)
//   last   out  combinational: pos is the final sample of the block
// BLK_N must be a power of two so the counter wraps by simple overflow.
module mat_pos_cnt
  import mat_pkg::*;
#(
  parameter int BLK_N = MAT_BLK_N,
  parameter int RW    = MAT_RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  output logic [RW-1:0] pos,
  output logic          last
);

  assign last = (pos == RW'(BLK_N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
    end else if (adv) begin
      pos <= pos + RW'(1);
    end
  end

endmodule

// File: rtl/mat_rle.sv
// mat_rle: run-length encoder downstream of mat_scan.
// Consumes 64 scanned coefficients per block and emits (run, level) pairs,
// with eob flagged on the last pair of each block. One cycle latency, all
// outputs registered and held while vld_out=0.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset (discards a partial block)
//   vld_in   in   din valid this cycle
//   din      in   scanned coefficient, DW bits two's complement
//   vld_out  out  run/level/eob valid this cycle
//   run      out  zeros preceding level
//   level    out  coefficient value (0 for ZRL or zero-tail eob)
//   eob      out  last output of the block, qualified by vld_out
// Build option: define MAT_RLE_ZRL_EN to cap runs at 15 and emit ZRL words
// (run=15, level=0, eob=0) when a zero arrives with 15 zeros pending.
module mat_rle
  import mat_pkg::*;
#(
  parameter int DW    = MAT_DW,
  parameter int BLK_N = MAT_BLK_N,
  parameter int RW    = MAT_RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld_in,
  input  logic [DW-1:0] din,
  output logic          vld_out,
  output logic [RW-1:0] run,
  output logic [DW-1:0] level,
  output logic          eob
);

  logic [RW-1:0] pos;
  logic          last;
  logic [RW-1:0] zcnt;
  logic [RW-1:0] zcnt_nxt;
  logic          emit;
  logic [RW-1:0] run_nxt;
  logic [DW-1:0] level_nxt;
  logic          eob_nxt;

  mat_pos_cnt #(
    .BLK_N (BLK_N),
    .RW    (RW)
  ) u_pos_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (vld_in),
    .pos   (pos),
    .last  (last)
  );

  always_comb begin
    emit      = 1'b0;
    run_nxt   = '0;
    level_nxt = '0;
    eob_nxt   = 1'b0;
    zcnt_nxt  = zcnt;
    if (vld_in) begin
      if (din != '0) begin
        emit      = 1'b1;
        run_nxt   = zcnt;
        level_nxt = din;
        eob_nxt   = last;
        zcnt_nxt  = '0;
      end else if (last) begin
        // Zero tail: the run includes this final zero; an all-zero block
        // wraps to run=0 and the consumer reads eob+level=0 as "rest zero".
        emit      = 1'b1;
        run_nxt   = zcnt + RW'(1);
        eob_nxt   = 1'b1;
        zcnt_nxt  = '0;
`ifdef MAT_RLE_ZRL_EN
      end else if (zcnt == RW'(MAT_ZRL_RUN)) begin
        emit      = 1'b1;
        run_nxt   = RW'(MAT_ZRL_RUN);
        zcnt_nxt  = '0;
`endif
      end else begin
        zcnt_nxt  = zcnt + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zcnt    <= '0;
      vld_out <= 1'b0;
      run     <= '0;
      level   <= '0;
      eob     <= 1'b0;
    end else begin
      zcnt    <= zcnt_nxt;
      vld_out <= emit;
      if (emit) begin
        run   <= run_nxt;
        level <= level_nxt;
        eob   <= eob_nxt;
      end
    end
  end

endmodule
